// File: rtl/rxfifo_pkg.sv
// Shared constants and helpers for the receive-side byte queue.
package rxfifo_pkg;

  // Width of the received byte and ceiling of the dropped-byte counter.
  localparam int unsigned     BYTE_W      = 8;
  localparam logic [7:0]      DROPPED_MAX = 8'hFF;

  // Increment that sticks at DROPPED_MAX instead of wrapping to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == DROPPED_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rxfifo_fifo_mem.sv
// Byte storage for the queue: one synchronous write port, one asynchronous
// read port, so it maps onto distributed RAM / LUTs and gives FWFT reads.
module fifo_mem #(
  parameter int unsigned LOG2DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG2DEPTH-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [LOG2DEPTH-1:0] raddr,
  output logic [7:0]           rdata
);

  localparam int unsigned DEPTH = 1 << LOG2DEPTH;

  // Contents are intentionally not reset; the pointers define what is valid.
  logic [7:0] mem_q [DEPTH];

  // Write port: store the incoming byte at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rxfifo.sv
// Receive buffer behind the serial receiver. Every byte the receiver holds is
// strobed out in the same cycle so the receiver can never miss a start bit;
// bytes that find the queue full are counted and flagged instead of stalling.
module rxfifo
  import rxfifo_pkg::*;
#(
  parameter int unsigned LOG2DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 uart_valid,
  input  logic [7:0]           uart_data,
  output logic                 uart_rd,
  input  logic                 rd,
  output logic                 valid,
  output logic [7:0]           data,
  output logic [LOG2DEPTH:0]   count,
  output logic                 full,
  output logic                 overrun,
  output logic [7:0]           dropped,
  input  logic                 clr_overrun
);

  localparam int unsigned            DEPTH      = 1 << LOG2DEPTH;
  localparam logic [LOG2DEPTH-1:0]   PTR_ONE    = LOG2DEPTH'(1);
  localparam logic [LOG2DEPTH:0]     CNT_ONE    = (LOG2DEPTH + 1)'(1);
  localparam logic [LOG2DEPTH:0]     FULL_COUNT = (LOG2DEPTH + 1)'(DEPTH);

  logic [LOG2DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2DEPTH-1:0] rptr_q, rptr_d;
  logic [LOG2DEPTH:0]   count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           dropped_q, dropped_d;

  logic pop, push, drop;

  // Flags come straight from the fill level so they can never disagree with it.
  assign valid   = (count_q != '0);
  assign full    = (count_q == FULL_COUNT);
  assign count   = count_q;
  assign overrun = overrun_q;
  assign dropped = dropped_q;

  // The receiver is always drained; a full queue drops rather than holds off.
  assign uart_rd = uart_valid;

  // A pop frees a slot in the same cycle, so a full queue still accepts then.
  assign pop  = rd & valid;
  assign push = uart_valid & (~full | pop);
  assign drop = uart_valid & full & ~pop;

  fifo_mem #(
    .LOG2DEPTH (LOG2DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (uart_data),
    .raddr (rptr_q),
    .rdata (data)
  );

  // Next-state for pointers, fill level and the overrun bookkeeping.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    dropped_d = dropped_q;

    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins, and counts as the first drop.
    if (drop) begin
      overrun_d = 1'b1;
      dropped_d = clr_overrun ? 8'd1 : sat_inc8(dropped_q);
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
      dropped_d = 8'd0;
    end
  end

  // State registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      dropped_q <= 8'd0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: doc/rxfifo.md
Name: rxfifo

Overview:
- Receive buffer directly downstream of the serial receiver (rxuart).
- Drains each received byte the cycle it becomes valid, so the receiver never stalls in its "holding data" state and misses a following start bit.
- Presents a first-word-fall-through byte queue to the CPU I/O decode, with fill level, a sticky overrun flag and a saturating dropped-byte counter.

Parameters:
- LOG2DEPTH, 4, log2 of queue depth. Depth = 2**LOG2DEPTH bytes. Legal range 1..8.

Ports:
- clk  input  1  system clock, all state on posedge.
- resetq  input  1  asynchronous active-low reset.
- uart_valid  input  1  receiver holds a complete byte.
- uart_data  input  8  receiver byte, stable while uart_valid.
- uart_rd  output  1  read strobe back to the receiver.
- rd  input  1  consumer pop strobe.
- valid  output  1  queue non-empty.
- data  output  8  head-of-queue byte.
- count  output  LOG2DEPTH+1  current fill level, 0..DEPTH.
- full  output  1  count == DEPTH.
- overrun  output  1  sticky: a byte was dropped.
- dropped  output  8  saturating count of dropped bytes.
- clr_overrun  input  1  clears overrun and dropped.

Behaviour:
- Clock and reset: single clock, clk. Reset resetq is asynchronous, active-low: all state registers in an always block sensitive to negedge resetq or posedge clk.
- Reset values: write pointer 0, read pointer 0, count 0, overrun 0, dropped 0. Hence valid=0, full=0, uart_rd=0 while uart_valid=0. Storage array is not reset.
- uart_rd = uart_valid, combinational, no gating by full.
  - The receiver deasserts valid on the next edge, so each byte produces exactly one strobe.
  - The receiver is never held off.
- Pop: pop = rd & valid. rd while empty is ignored; no pointer movement, no error.
- Push: push = uart_valid & (~full | pop).
  - On push: mem[wptr] <= uart_data, wptr increments.
  - Pointers are LOG2DEPTH bits wide and wrap naturally at DEPTH.
- Pop moves rptr by +1 with wrap.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push with pop, or on neither.
- Full with simultaneous pop: push is accepted. Count stays DEPTH and the new byte lands in the freed slot.
- Drop: drop = uart_valid & full & ~pop.
  - Byte is discarded.
  - overrun <= 1.
  - dropped <= dropped + 1, saturating at 255.
- clr_overrun: sets overrun <= 0 and dropped <= 0. If drop occurs in the same cycle, the drop wins: overrun=1, dropped=1.
- data = mem[rptr], combinational read (FWFT).
  - Meaningful only while valid=1; X/stale otherwise.
  - A pushed byte is visible on data/valid the cycle after the push edge (1-cycle latency, empty to valid).
- Empty with simultaneous push and rd: rd is ignored because valid=0. The byte appears next cycle.
- Reset mid-operation: queue contents are lost immediately (count 0). The receiver may still hold a byte; it is drained normally after resetq rises.
- Flags are derived from count (valid = count!=0, full = count==DEPTH). No separate flag registers, so they cannot desynchronise.

Decomposition:
- No shared package required.
- DEPTH is a localparam computed from LOG2DEPTH inside the block.
- One natural sub-module: fifo_mem, a 2**LOG2DEPTH x 8 array with one synchronous write port and one asynchronous read port. It keeps the storage inferable as distributed RAM/LUTs on iCE40 and is reusable by a later TX-side queue.
- The top-level rxfifo holds pointers, count, overrun/dropped logic and the receiver handshake.
- Integration: a receive-side wrapper instantiates rxuart and rxfifo, wiring valid->uart_valid, data->uart_data and uart_rd->rd.

Test Plan:
1. Reset then idle: after resetq rises, valid=0, count=0, full=0, overrun=0, dropped=0, uart_rd=0.
2. Single byte, LOG2DEPTH=4: pulse uart_valid one cycle with uart_data=8'hA5 -> uart_rd=1 that cycle; next cycle valid=1, data=8'hA5, count=1. Then rd=1 for one cycle -> valid=0, count=0.
3. Fill and order: push 16 bytes 8'h00..8'h0F -> full=1, count=16, overrun=0. Pop 16 -> data sequence 00..0F in order, then valid=0. Pointers wrap cleanly on a second 16-byte pass.
4. Overrun: with full=1 and rd=0, push 8'hEE, then 8'hEF -> both dropped, overrun=1, dropped=2, contents still 00..0F. Then clr_overrun=1 -> overrun=0, dropped=0.
5. Full with simultaneous push/pop: full, rd=1 and uart_valid=1 with 8'h77 in the same cycle -> no drop, count stays 16, head advances by one, 8'h77 is popped last.
6. Saturation and priority: 300 drops while full -> dropped=255. clr_overrun coincident with a drop -> overrun=1, dropped=1. Assert resetq low mid-fill -> count=0 and valid=0 asynchronously, before the next clk edge.
